// File: rtl/packetizer.sv
// Packetizer: turns a message descriptor plus payload words into head/body/tail
// flits for the router local port and discards descriptors that cannot be routed.
module packetizer #(
  parameter logic [3:0] Addr = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [3:0]  msg_dest,
  input  logic [3:0]  msg_len,
  input  logic        pay_valid,
  output logic        pay_ready,
  input  logic [29:0] pay_data,
  output logic [31:0] flit_out,
  output logic        flit_valid,
  input  logic        flit_ready,
  output logic [1:0]  flit_type,
  output logic        drop_err
);

  typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, DROP} state_e;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  state_e      state_q, state_d;
  logic [5:0]  seq_q, seq_d;
  logic [3:0]  rem_q, rem_d;
  logic [31:0] flit_q, flit_d;
  logic        flit_valid_q, flit_valid_d;
  logic        drop_q, drop_d;

  logic out_free, msg_acc, pay_acc, flit_taken, dest_bad, last_word;

  // The output register can take a new flit if it is empty or being drained now.
  assign out_free   = !flit_valid_q || flit_ready;
  assign flit_taken = enable && flit_valid_q && flit_ready;
  assign msg_ready  = enable && (state_q == IDLE) && out_free;
  assign pay_ready  = enable && ((state_q == DROP) ||
                                 (((state_q == HEAD) || (state_q == PAYLOAD)) && out_free));
  assign msg_acc    = msg_valid && msg_ready;
  assign pay_acc    = pay_valid && pay_ready;
  assign last_word  = (rem_q == 4'd1);
  assign dest_bad   = (msg_dest[3:2] == 2'd3) || (msg_dest[1:0] == 2'd3) || (msg_dest == Addr);

  always_comb begin
    // NOTE: every next-state value gets a default first so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d      = state_q;
    seq_d        = seq_q;
    rem_d        = rem_q;
    flit_d       = flit_q;
    flit_valid_d = flit_valid_q;
    drop_d       = drop_q;

    if (enable) begin
      drop_d = 1'b0;
      if (flit_taken) begin
        flit_valid_d = 1'b0;
        if (flit_q[31:30] == FT_HEAD) seq_d = seq_q + 6'd1;
      end

      case (state_q)
        IDLE: begin
          if (msg_acc) begin
            if (msg_len == 4'd0) begin
              drop_d = 1'b1;
            end else if (dest_bad) begin
              drop_d  = 1'b1;
              rem_d   = msg_len;
              state_d = DROP;
            end else begin
              flit_d       = {FT_HEAD, msg_dest, Addr, msg_len, seq_q, 12'h000};
              flit_valid_d = 1'b1;
              rem_d        = msg_len;
              state_d      = HEAD;
            end
          end
        end
        HEAD, PAYLOAD: begin
          // A load overrides the clear above, so a take plus load keeps valid high.
          if (pay_acc) begin
            flit_d       = {(last_word ? FT_TAIL : FT_BODY), pay_data};
            flit_valid_d = 1'b1;
            rem_d        = rem_q - 4'd1;
            state_d      = last_word ? IDLE : PAYLOAD;
          end
        end
        DROP: begin
          if (pay_acc) begin
            rem_d = rem_q - 4'd1;
            if (last_word) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      seq_q        <= '0;
      rem_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seq_q        <= seq_d;
      rem_q        <= rem_d;
      flit_q       <= flit_d;
      flit_valid_q <= flit_valid_d;
      drop_q       <= drop_d;
    end
  end

  assign flit_out   = flit_q;
  assign flit_valid = flit_valid_q;
  assign flit_type  = flit_q[31:30];
  assign drop_err   = drop_q;

endmodule
